// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_STALL = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } next_pc_sel_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Pick the next PC among sequential, branch and jump candidates.
  function automatic logic [31:0] select_next(input next_pc_sel_t sel,
                                              input logic [31:0] seq_pc,
                                              input logic [31:0] branch_pc,
                                              input logic [31:0] jump_pc);
    case (sel)
      SEL_JUMP:   return jump_pc;
      SEL_BRANCH: return branch_pc;
      default:    return seq_pc;
    endcase
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-cycle counter for an outstanding fetch; flags the cycle that reaches the limit.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q;

  // Count enabled wait cycles; clear has priority over counting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else if (clr_i) begin
      count_q <= 8'd0;
    end else if (en_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  // The current wait cycle is the LIMIT-th one when the count already holds LIMIT-1.
  assign expired_o = en_i && (count_q == (LIMIT - 8'd1));

endmodule

// File: rtl/fetch_sequencer.sv
// PC / instruction-fetch sequencer: boot, fetch handshake, redirects, load-use stall, watchdog.
//
// Handshake: imem_req_o stays high (address = pc_i) for every FETCH cycle until
// imem_ready_i is seen high; the cycle with req & ready completes the transfer and
// imem_rdata_i is consumed in that same cycle. There is no separate accept phase.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [31:0]  pc_i,
  output logic [31:0]  pc_next_o,
  output logic         pc_hold_o,
  input  logic         jump_i,
  input  logic [31:0]  jump_target_i,
  input  logic         branch_i,
  input  logic [31:0]  branch_target_i,
  input  logic         load_use_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_ready_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  instr_o,
  output logic         instr_valid_o,
  output logic         flush_o,
  output logic         fetch_err_o,
  output fetch_state_t state_o
);

  fetch_state_t state_q, state_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  buf_q, buf_d;
  logic         stop_q, stop_d;
  logic         err_q, err_d;

  logic         redir;
  logic         stopping;
  next_pc_sel_t redir_sel;
  logic [31:0]  seq_pc;
  logic [31:0]  redir_tgt;
  logic [31:0]  instr_src;
  logic         wd_expired;

  assign redir     = jump_i | branch_i;
  assign redir_sel = jump_i ? SEL_JUMP : (branch_i ? SEL_BRANCH : SEL_SEQ);
  assign seq_pc    = pc_i + PC_STEP;
  assign redir_tgt = select_next(redir_sel, seq_pc, branch_target_i, jump_target_i);
  // A stop request seen at any point of an outstanding fetch is remembered until it drains.
  assign stopping  = stop_q | ~start_i;

  fetch_watchdog #(.LIMIT(8'(TIMEOUT))) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     ((state_q != ST_FETCH) | imem_ready_i),
    .en_i      ((state_q == ST_FETCH) & ~imem_ready_i),
    .expired_o (wd_expired)
  );

  // Per-cycle decisions: PC control, fetch request, instruction issue and next state.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    buf_d         = buf_q;
    stop_d        = stop_q;
    err_d         = err_q;
    pc_hold_o     = 1'b1;
    pc_next_o     = seq_pc;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    instr_src     = imem_rdata_i;
    flush_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_next_o = RESET_PC;
        stop_d    = 1'b0;
        pend_d    = 1'b0;
        if (start_i) state_d = ST_INIT;
      end
      ST_INIT: begin
        pc_next_o = RESET_PC;
        pc_hold_o = 1'b0;
        state_d   = start_i ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        imem_req_o = 1'b1;
        flush_o    = redir;
        stop_d     = stopping;
        if (imem_ready_i) begin
          pend_d = 1'b0;
          if (stopping) begin
            // Request drained; data discarded and PC left where it is.
            state_d = ST_IDLE;
          end else if (redir) begin
            pc_hold_o = 1'b0;
            pc_next_o = redir_tgt;
          end else if (pend_q) begin
            // Data belongs to the wrong path; the latched target takes effect now.
            pc_hold_o = 1'b0;
            pc_next_o = pend_tgt_q;
          end else if (load_use_i) begin
            buf_d   = imem_rdata_i;
            state_d = ST_STALL;
          end else begin
            pc_hold_o     = 1'b0;
            instr_valid_o = 1'b1;
          end
        end else begin
          if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end
          if (wd_expired) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_STALL: begin
        flush_o = redir;
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (redir) begin
          // Buffered instruction is wrong-path; no request is open, so load the target now.
          pc_hold_o = 1'b0;
          pc_next_o = redir_tgt;
          state_d   = ST_FETCH;
        end else if (!load_use_i) begin
          pc_hold_o     = 1'b0;
          instr_valid_o = 1'b1;
          instr_src     = buf_q;
          state_d       = ST_FETCH;
        end
      end
      ST_ERR: begin
        pc_next_o = RESET_PC;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset returns to IDLE and abandons any request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
      buf_q      <= 32'd0;
      stop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      buf_q      <= buf_d;
      stop_q     <= stop_d;
      err_q      <= err_d;
    end
  end

  assign imem_addr_o = pc_i;
  assign instr_o     = instr_valid_o ? instr_src : 32'd0;
  assign fetch_err_o = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, watchdog sequence, random run vs model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h100;
  localparam int          TMO  = 4;
  localparam logic        H    = 1'b1;
  localparam logic        L    = 1'b0;

  typedef struct {
    logic        start, jump, branch, lu, rdy;
    logic [31:0] jt, bt, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_hold;
    logic [31:0] e_next;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_flush;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start, jump, branch, load_use, ready;
  logic [31:0]  jt, bt, rdata, pc;
  logic [31:0]  pc_next, imem_addr, instr;
  logic         pc_hold, imem_req, instr_valid, flush, fetch_err;
  fetch_state_t state;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(BOOT), .TIMEOUT(TMO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .pc_i            (pc),
    .pc_next_o       (pc_next),
    .pc_hold_o       (pc_hold),
    .jump_i          (jump),
    .jump_target_i   (jt),
    .branch_i        (branch),
    .branch_target_i (bt),
    .load_use_i      (load_use),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ready_i    (ready),
    .imem_rdata_i    (rdata),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .flush_o         (flush),
    .fetch_err_o     (fetch_err),
    .state_o         (state)
  );

  // PC register controlled by the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else if (!pc_hold) pc <= pc_next;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic j, input logic [31:0] jtv,
                       input logic b, input logic [31:0] btv, input logic lu,
                       input logic r, input logic [31:0] rd);
    start = s; jump = j; jt = jtv; branch = b; bt = btv;
    load_use = lu; ready = r; rdata = rd;
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_hold, input logic [31:0] e_next, input logic e_valid,
                           input logic [31:0] e_instr, input logic e_flush, input logic e_err);
    check1({tag, ".req"}, imem_req, e_req);
    if (e_req) check32({tag, ".addr"}, imem_addr, e_addr);
    check1({tag, ".hold"}, pc_hold, e_hold);
    if (!e_hold) check32({tag, ".pc_next"}, pc_next, e_next);
    check1({tag, ".valid"}, instr_valid, e_valid);
    if (e_valid) check32({tag, ".instr"}, instr, e_instr);
    check1({tag, ".flush"}, flush, e_flush);
    check1({tag, ".err"}, fetch_err, e_err);
  endtask

  function automatic vec_t mkv(input logic s, input logic j, input logic [31:0] jtv,
                               input logic b, input logic [31:0] btv, input logic lu,
                               input logic r, input logic [31:0] rd,
                               input logic e_req, input logic [31:0] e_addr, input logic e_hold,
                               input logic [31:0] e_next, input logic e_valid,
                               input logic [31:0] e_instr, input logic e_flush);
    vec_t v;
    v.start = s; v.jump = j; v.jt = jtv; v.branch = b; v.bt = btv; v.lu = lu;
    v.rdy = r; v.rdata = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_hold = e_hold;
    v.e_next = e_next; v.e_valid = e_valid; v.e_instr = e_instr; v.e_flush = e_flush;
    return v;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds an instruction parked by a load-use stall; pend_q a redirect target
  // waiting for its fetch to complete.
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];
  bit          m_active, m_init, m_stop, m_err;
  int          m_wait;
  logic [31:0] m_pc;

  task automatic model_reset();
    exp_q.delete(); pend_q.delete();
    m_active = 0; m_init = 0; m_stop = 0; m_err = 0; m_wait = 0; m_pc = 32'd0;
  endtask

  task automatic model_step(input string tag);
    logic        redir, e_req, e_hold, e_valid, e_flush, e_err;
    logic [31:0] tgt, e_addr, e_next, e_instr;
    redir = jump | branch;
    tgt   = jump ? jt : bt;
    e_req = 0; e_hold = 1; e_valid = 0; e_flush = 0;
    e_addr = 32'd0; e_next = 32'd0; e_instr = 32'd0;
    e_err = m_err;
    if (m_err) begin
      // stuck until reset
    end else if (m_init) begin
      e_hold = 0; e_next = BOOT; m_pc = BOOT;
      m_init = 0; m_active = start;
    end else if (!m_active) begin
      if (start) m_init = 1;
    end else if (exp_q.size() > 0) begin
      e_flush = redir;
      if (!start) begin
        exp_q.delete(); m_active = 0;
      end else if (redir) begin
        exp_q.delete(); e_hold = 0; e_next = tgt; m_pc = tgt;
      end else if (!load_use) begin
        e_valid = 1; e_instr = exp_q.pop_front();
        e_hold = 0; e_next = m_pc + 32'd4; m_pc = e_next;
      end
    end else begin
      e_req = 1; e_addr = m_pc; e_flush = redir;
      if (!start) m_stop = 1;
      if (ready) begin
        m_wait = 0;
        if (m_stop) begin
          m_active = 0; m_stop = 0; pend_q.delete();
        end else if (redir) begin
          pend_q.delete(); e_hold = 0; e_next = tgt; m_pc = tgt;
        end else if (pend_q.size() > 0) begin
          e_hold = 0; e_next = pend_q.pop_front(); m_pc = e_next;
        end else if (load_use) begin
          exp_q.push_back(rdata);
        end else begin
          e_valid = 1; e_instr = rdata;
          e_hold = 0; e_next = m_pc + 32'd4; m_pc = e_next;
        end
      end else begin
        if (redir) begin pend_q.delete(); pend_q.push_back(tgt); end
        m_wait++;
        if (m_wait == TMO) begin m_err = 1; m_active = 0; end
      end
    end
    check_all(tag, e_req, e_addr, e_hold, e_next, e_valid, e_instr, e_flush, e_err);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(L, L, 32'd0, L, 32'd0, L, L, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1({tag, ".state_idle"}, state == ST_IDLE, H);
    check1({tag, ".hold"}, pc_hold, H);
    check32({tag, ".pc_next"}, pc_next, BOOT);
    check1({tag, ".req"}, imem_req, L);
    check1({tag, ".valid"}, instr_valid, L);
    check1({tag, ".flush"}, flush, L);
    check1({tag, ".err"}, fetch_err, L);
    check32({tag, ".instr"}, instr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[17];

  initial begin
    logic s_lvl, lu_lvl, r;

    vecs[0]  = mkv(H,L,32'h0,L,32'h0,L,L,32'h0,                L,32'h0,H,32'h0,L,32'h0,L);
    vecs[1]  = mkv(H,L,32'h0,L,32'h0,L,L,32'h0,                L,32'h0,L,BOOT,L,32'h0,L);
    vecs[2]  = mkv(H,L,32'h0,L,32'h0,L,H,32'hA000_0000,        H,32'h100,L,32'h104,H,32'hA000_0000,L);
    vecs[3]  = mkv(H,L,32'h0,L,32'h0,H,H,32'hA000_0001,        H,32'h104,H,32'h0,L,32'h0,L);
    vecs[4]  = mkv(H,L,32'h0,L,32'h0,H,L,32'h0,                L,32'h0,H,32'h0,L,32'h0,L);
    vecs[5]  = mkv(H,L,32'h0,L,32'h0,H,H,32'h0,                L,32'h0,H,32'h0,L,32'h0,L);
    vecs[6]  = mkv(H,L,32'h0,L,32'h0,L,L,32'h0,                L,32'h0,L,32'h108,H,32'hA000_0001,L);
    vecs[7]  = mkv(H,L,32'h0,L,32'h0,L,H,32'hA000_0002,        H,32'h108,L,32'h10C,H,32'hA000_0002,L);
    vecs[8]  = mkv(H,H,32'h200,L,32'h0,L,H,32'hA000_0003,      H,32'h10C,L,32'h200,L,32'h0,H);
    vecs[9]  = mkv(H,L,32'h0,H,32'h400,L,L,32'h0,              H,32'h200,H,32'h0,L,32'h0,H);
    vecs[10] = mkv(H,L,32'h0,L,32'h0,L,L,32'h0,                H,32'h200,H,32'h0,L,32'h0,L);
    vecs[11] = mkv(H,L,32'h0,L,32'h0,L,H,32'hA000_0004,        H,32'h200,L,32'h400,L,32'h0,L);
    vecs[12] = mkv(H,H,32'h800,H,32'h400,L,H,32'hA000_0005,    H,32'h400,L,32'h800,L,32'h0,H);
    vecs[13] = mkv(H,H,32'hFFFF_FFFC,L,32'h0,L,H,32'hA000_0006,H,32'h800,L,32'hFFFF_FFFC,L,32'h0,H);
    vecs[14] = mkv(H,L,32'h0,L,32'h0,L,H,32'hA000_0007,        H,32'hFFFF_FFFC,L,32'h0,H,32'hA000_0007,L);
    vecs[15] = mkv(H,L,32'h0,H,32'h300,H,H,32'hA000_0008,      H,32'h0,L,32'h300,L,32'h0,H);
    vecs[16] = mkv(H,L,32'h0,L,32'h0,L,H,32'hA000_0009,        H,32'h300,L,32'h304,H,32'hA000_0009,L);

    do_reset("reset0");

    // directed table: boot, load-use, branch in wait, jump+branch, wrap, redirect vs load-use
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].start, vecs[i].jump, vecs[i].jt, vecs[i].branch, vecs[i].bt,
            vecs[i].lu, vecs[i].rdy, vecs[i].rdata);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_hold,
                vecs[i].e_next, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_flush, L);
      @(posedge clk); #1;
    end

    // watchdog: fetch at 0x304 never answered
    for (int i = 0; i < TMO; i++) begin
      drive(H, L, 32'd0, L, 32'd0, L, L, 32'd0);
      @(negedge clk);
      check1($sformatf("wd_wait%0d.req", i), imem_req, H);
      check1($sformatf("wd_wait%0d.err", i), fetch_err, L);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check1("wd_err_set", fetch_err, H);
    check1("wd_req_dropped", imem_req, L);
    check1("wd_pc_held", pc_hold, H);
    check1("wd_state_err", state == ST_ERR, H);
    @(posedge clk); #1;
    drive(L, L, 32'd0, L, 32'd0, L, H, 32'd0);
    @(posedge clk); #1;
    drive(H, L, 32'd0, L, 32'd0, L, H, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("wd_err_sticky", fetch_err, H);
    check1("wd_sticky_no_req", imem_req, L);
    #2 rst = 1'b1;
    #1;
    check1("wd_rst_clears_err", fetch_err, L);
    check1("wd_rst_state_idle", state == ST_IDLE, H);

    // randomized run against the reference model
    do_reset("reset1");
    s_lvl  = 1'b1;
    lu_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 3) == 0) lu_lvl = ~lu_lvl;
      r = (m_wait >= TMO - 2) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(s_lvl, $urandom_range(0, 7) == 0, $urandom() & 32'hFFFF_FFFC,
            $urandom_range(0, 7) == 0, $urandom() & 32'hFFFF_FFFC,
            lu_lvl, r, $urandom());
      @(negedge clk);
      model_step($sformatf("rnd%0d", n));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute time bound
  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got=expired expected=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit reached");
  end

endmodule
